// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : alu_defs (package)
//  Description : Shared ALU definitions: datapath width and the multiplier
//                control state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_defs;

    localparam int ALU_WIDTH = 8;

    // 2'd3 is unused and decodes back to ST_IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/twos_complement.sv
`default_nettype none
// ============================================================================
//  Module      : twos_complement
//  Description : Two's-complement negation (invert + 1) as an explicit
//                half-adder ripple chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_complement
    import alu_defs::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_carry;

    assign w_inv      = ~i_a;
    assign w_carry[0] = 1'b1;

    // Each bit is a half adder on the inverted input; the final carry-out
    // is not needed and is never formed.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_y[i] = w_inv[i] ^ w_carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign w_carry[i+1] = w_inv[i] & w_carry[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/twos_complement16.sv
`default_nettype none
// ============================================================================
//  Module      : twos_complement16
//  Description : 16-bit two's-complement negation (invert + 1) ripple chain,
//                used to restore the sign of the final product.
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_complement16 (
    input  logic [15:0] i_a,
    output logic [15:0] o_y
);

    localparam int c_W = 16;

    logic [c_W-1:0] w_inv;
    logic [c_W-1:0] w_carry;

    assign w_inv      = ~i_a;
    assign w_carry[0] = 1'b1;

    // Half-adder ripple on the inverted input; no carry-out is formed.
    for (genvar i = 0; i < c_W; i++) begin : g_bit
        assign o_y[i] = w_inv[i] ^ w_carry[i];
        if (i < c_W - 1) begin : g_carry
            assign w_carry[i+1] = w_inv[i] & w_carry[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/signed_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seq_multiplier
//  Description : Multi-cycle signed WIDTHxWIDTH -> 2*WIDTH multiplier.
//                Operands are reduced to magnitudes, an unsigned shift-add
//                loop runs for WIDTH cycles, and the product is negated when
//                the operand signs differ. start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_seq_multiplier
    import alu_defs::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Last shift-add iteration, and the second (commit) cycle of FIX.
    localparam logic [CNT_W-1:0] c_LAST_ITER  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_FIX_COMMIT = CNT_W'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_busy;

    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_count;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_neg_a;
    logic [WIDTH-1:0]     w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_raw;
    logic [2*WIDTH-1:0]   w_raw_neg;
    logic [2*WIDTH-1:0]   w_fixed;

    twos_complement #(.WIDTH(WIDTH)) u_neg_a (.i_a(a), .o_y(w_neg_a));
    twos_complement #(.WIDTH(WIDTH)) u_neg_b (.i_a(b), .o_y(w_neg_b));
    twos_complement16                u_neg_p (.i_a(w_raw), .o_y(w_raw_neg));

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct
    // magnitude, so no extra bit is needed.
    assign w_mag_a = a[WIDTH-1] ? w_neg_a : a;
    assign w_mag_b = b[WIDTH-1] ? w_neg_b : b;

    // Upper accumulator half plus the (conditional) multiplicand; the carry
    // bit is shifted straight back into the accumulator.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_a} : '0);
    assign w_raw   = {r_hi, r_lo};
    assign w_fixed = r_neg ? w_raw_neg : w_raw;

    assign busy    = w_busy;
    assign done    = r_done;
    assign product = r_product;

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and busy decode. FIX spans two cycles: the first lets the
    // 16-bit ripple negation settle, the second commits the product.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_count == c_LAST_ITER) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                w_busy = 1'b1;
                if (r_count == c_FIX_COMMIT) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and result commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mag_a <= w_mag_a;
                        r_lo    <= w_mag_b;
                        r_hi    <= '0;
                        r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    r_hi    <= w_sum[WIDTH:1];
                    r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
                    // Wraps to zero on the last iteration, ready for FIX.
                    r_count <= r_count + 1'b1;
                end
                ST_FIX: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == c_FIX_COMMIT) begin
                        r_product <= w_fixed;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_seq_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_signed_seq_multiplier
//  Description : Directed self-checking bench for signed_seq_multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    signed_seq_multiplier #(.WIDTH(8), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from IDLE and wait (bounded) for done.
    // lat counts edges after the accept edge; bcnt counts busy-high samples.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] p, output int lat,
                          output int bcnt, output bit tmo);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; tmo = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        p = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h want=0000", product); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] p; int lat; int bcnt; bit tmo;
        run_op(8'd3, 8'd5, p, lat, bcnt, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
        checks++; if (p !== 16'h000F) begin errors++; $display("FAIL basic_product got=%h want=000F", p); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got=%0d want=10", lat); end
        checks++; if (bcnt !== 10) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=10", bcnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_hold got=%h want=000F", product); end
    endtask

    task automatic test_signs();
        logic [7:0]  va [7] = '{8'hFD, 8'h07, 8'hFC, 8'h80, 8'h80, 8'h7F, 8'h00};
        logic [7:0]  vb [7] = '{8'h05, 8'hFE, 8'hFC, 8'h80, 8'h7F, 8'h7F, 8'hFF};
        logic [15:0] vp [7] = '{16'hFFF1, 16'hFFF2, 16'h0010, 16'h4000,
                                16'hC080, 16'h3F01, 16'h0000};
        logic [15:0] p; int lat; int bcnt; bit tmo;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], p, lat, bcnt, tmo);
            checks++;
            if (tmo || p !== vp[i]) begin
                errors++;
                $display("FAIL signs_%0d %h*%h got=%h want=%h timeout=%0d", i, va[i], vb[i], p, vp[i], tmo);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [15:0] p = 16'hXXXX;
        a = 8'd2; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 6) begin
                start = 1'b1; a = 8'd9; b = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                p = product;
            end
        end
        start = 1'b0;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
        checks++; if (p !== 16'h0006) begin errors++; $display("FAIL ignore_product got=%h want=0006", p); end
    endtask

    task automatic test_async_reset();
        int ndone = 0;
        logic [15:0] p; int lat; int bcnt; bit tmo;
        a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b want=0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL areset_product got=%h want=0000", product); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL areset_spurious got=%0d want=0", ndone); end
        run_op(8'h06, 8'hF9, p, lat, bcnt, tmo);
        checks++; if (tmo || p !== 16'hFFD6) begin errors++; $display("FAIL areset_newop got=%h want=FFD6", p); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]         qa;
        logic [7:0]         qb;
        logic signed [15:0] exp_p;
        logic [15:0]        prev = '0;
        int                 since;
        int                 bad_interval = 0;
        int                 bad_hold = 0;
        bit                 got;
        qa = 8'h80; qb = 8'h80;
        a = qa; b = qb; start = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 500; n++) begin
            exp_p = $signed(qa) * $signed(qb);
            got   = 1'b0;
            since = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                since++;
                if (done) begin
                    got = 1'b1;
                    break;
                end
                if (n > 0 && product !== prev) bad_hold++;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL b2b_timeout op=%0d got=no_done want=done", n);
                break;
            end
            if (since != ((n == 0) ? 10 : 11)) bad_interval++;
            checks++;
            if (product !== exp_p) begin
                errors++;
                $display("FAIL b2b_product op=%0d %h*%h got=%h want=%h", n, qa, qb, product, exp_p);
            end
            prev = product;
            qa = 8'($urandom); qb = 8'($urandom);
            a = qa; b = qb;
        end
        start = 1'b0;
        checks++; if (bad_interval !== 0) begin errors++; $display("FAIL b2b_interval got=%0d_bad want=0", bad_interval); end
        checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_hold got=%0d_bad want=0", bad_hold); end
        repeat (15) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
